// File: rtl/button_debounce_irq_ctrl.sv
// button_debounce_irq_ctrl
// Avalon-MM push-button controller: per-bit 2-FF synchroniser, counter-based
// debounce, polarity-selected edge capture into sticky W1C flags and a
// maskable, registered level interrupt. Register map (word address):
//   0 DATA (RO), 1 MASK (RW), 2 CAPTURE (W1C), 3 POLARITY (RW).
// DEBOUNCE_CYCLES must be at least 2 and must fit in CNT_W bits.
`timescale 1ns/1ps

module button_debounce_irq_ctrl #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_MASK     = 2'd1;
    localparam logic [1:0] ADDR_CAPTURE  = 2'd2;
    localparam logic [1:0] ADDR_POLARITY = 2'd3;

    // Per-bit debounce states: IDLE while the synchronised pin agrees with
    // the accepted level, COUNT while it disagrees.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_COUNT = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] qualified;
    logic [WIDTH-1:0] edge_event;
    logic [WIDTH-1:0] capture;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] polarity;
    logic [WIDTH-1:0] wr_bits;
    logic [WIDTH-1:0] clear_bits;
    logic             wr_en;
    logic [31:0]      read_mux;
    logic             unused_writedata;

    // Two-stage synchroniser for the asynchronous pins, nothing between stages
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
        logic [0:0]       state;
        logic [CNT_W-1:0] count;
        logic             stable_bit;

        // Debounce FSM: accept the new level after DEBOUNCE_CYCLES disagreeing cycles
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state      <= ST_IDLE;
                count      <= '0;
                stable_bit <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (sync2[i] != stable_bit) begin
                            state <= ST_COUNT;
                            count <= CNT_ONE;
                        end else begin
                            count <= '0;
                        end
                    end
                    default: begin
                        if (sync2[i] == stable_bit) begin
                            state <= ST_IDLE;
                            count <= '0;
                        end else if (count == CNT_LAST) begin
                            stable_bit <= sync2[i];
                            state      <= ST_IDLE;
                            count      <= '0;
                        end else begin
                            count <= count + CNT_ONE;
                        end
                    end
                endcase
            end
        end

        assign accept[i] = (state == ST_COUNT) && (sync2[i] != stable_bit) && (count == CNT_LAST);
        assign stable[i] = stable_bit;
    end

    // In an accept cycle the new level equals sync2, so polarity picks rise or fall
    assign qualified = accept & ~(polarity ^ sync2);

    // Register the qualified edges so capture sets one cycle after the stable change
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_event <= '0;
        end else begin
            edge_event <= qualified;
        end
    end

    assign wr_en            = chipselect && !write_n;
    assign wr_bits          = writedata[WIDTH-1:0];
    assign clear_bits       = (wr_en && (address == ADDR_CAPTURE)) ? wr_bits : '0;
    assign unused_writedata = ^writedata[31:WIDTH];

    // Sticky capture flags: W1C clear, with a same-cycle set taking priority
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            capture <= '0;
        end else begin
            capture <= (capture & ~clear_bits) | edge_event;
        end
    end

    // Interrupt mask and edge polarity registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask     <= '0;
            polarity <= '1;
        end else if (wr_en) begin
            if (address == ADDR_MASK) begin
                mask <= wr_bits;
            end
            if (address == ADDR_POLARITY) begin
                polarity <= wr_bits;
            end
        end
    end

    // Read mux, unused upper bits read as zero
    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_DATA:     read_mux[WIDTH-1:0] = stable;
            ADDR_MASK:     read_mux[WIDTH-1:0] = mask;
            ADDR_CAPTURE:  read_mux[WIDTH-1:0] = capture;
            ADDR_POLARITY: read_mux[WIDTH-1:0] = polarity;
            default:       read_mux = '0;
        endcase
    end

    // Registered read data and level interrupt, updated every clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= read_mux;
            irq      <= |(capture & mask);
        end
    end

endmodule

// File: tb/tb_button_debounce_irq_ctrl.sv
// tb_button_debounce_irq_ctrl
// Directed scenarios plus randomised pin/bus traffic, compared every cycle
// against a behavioural model: a pin level is accepted once the last
// DEBOUNCE_CYCLES synchronised samples all disagree with the accepted level.
`timescale 1ns/1ps

module tb_button_debounce_irq_ctrl;

    localparam int W    = 4;
    localparam int DEB  = 8;
    localparam int HIST = DEB + 3;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [31:0]  writedata;
    logic [W-1:0] in_port;
    logic [31:0]  readdata;
    logic         irq;

    int checkCount = 0;
    int failCount  = 0;

    // Behavioural model state
    logic [W-1:0] histQ[$];
    logic [W-1:0] mStable;
    logic [W-1:0] mMask;
    logic [W-1:0] mCap;
    logic [W-1:0] mPol;
    logic [W-1:0] mEvq;
    logic         mIrq;
    logic [31:0]  mRead;

    button_debounce_irq_ctrl #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic resetModel();
        histQ.delete();
        for (int k = 0; k < HIST - 1; k++) histQ.push_back('0);
        mStable = '0;
        mMask   = '0;
        mCap    = '0;
        mPol    = '1;
        mEvq    = '0;
        mIrq    = 1'b0;
        mRead   = '0;
    endtask

    // One clock edge of the model, using the inputs present at that edge
    task automatic stepModel();
        logic [W-1:0] acc;
        logic [W-1:0] newStable;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] events;
        logic [W-1:0] wrBits;
        logic [W-1:0] clearBits;
        logic         wrEn;
        int           last;
        if (!reset_n) begin
            resetModel();
            return;
        end
        histQ.push_back(in_port);
        if (histQ.size() > HIST) void'(histQ.pop_front());
        last = histQ.size() - 1;
        for (int b = 0; b < W; b++) begin
            acc[b] = 1'b1;
            for (int k = 2; k < DEB + 2; k++) begin
                if (histQ[last - k][b] == mStable[b]) acc[b] = 1'b0;
            end
        end
        newStable = mStable ^ acc;
        rise      = acc & newStable;
        fall      = acc & ~newStable;
        events    = (mPol & rise) | (~mPol & fall);
        wrEn      = chipselect && !write_n;
        wrBits    = writedata[W-1:0];
        clearBits = (wrEn && address == 2'd2) ? wrBits : '0;
        if (address == 2'd0)      mRead = {28'b0, mStable};
        else if (address == 2'd1) mRead = {28'b0, mMask};
        else if (address == 2'd2) mRead = {28'b0, mCap};
        else                      mRead = {28'b0, mPol};
        mIrq    = |(mCap & mMask);
        mCap    = (mCap & ~clearBits) | mEvq;
        mEvq    = events;
        mStable = newStable;
        if (wrEn && address == 2'd1) mMask = wrBits;
        if (wrEn && address == 2'd3) mPol  = wrBits;
    endtask

    task automatic tick();
        @(posedge clk);
        stepModel();
        #1;
        checkOutput("readdata", readdata, mRead);
        checkOutput("irq", {31'b0, irq}, {31'b0, mIrq});
    endtask

    task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic busRead(input logic [1:0] addr, output logic [31:0] value);
        address = addr;
        tick();
        value = readdata;
    endtask

    task automatic applyStimulus(input int rounds);
        int hold;
        for (int r = 0; r < rounds; r++) begin
            if ($urandom_range(0, 2) != 0) in_port = in_port ^ W'($urandom_range(1, 15));
            if ($urandom_range(0, 1) == 1) hold = $urandom_range(1, DEB - 1);
            else                           hold = $urandom_range(DEB, 2 * DEB + 4);
            for (int c = 0; c < hold; c++) begin
                address    = 2'($urandom_range(0, 3));
                chipselect = ($urandom_range(0, 3) == 0);
                write_n    = ($urandom_range(0, 1) == 0);
                writedata  = $urandom();
                tick();
            end
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        #10_000_000;
        failCount++;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

    initial begin
        logic [31:0] value;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        resetModel();
        repeat (2) tick();
        #2 reset_n = 1'b1;

        // Reset values
        busRead(2'd3, value);
        checkOutput("resetPolarity", value, 32'h0000_000F);
        busRead(2'd1, value);
        checkOutput("resetMask", value, 32'h0);

        // Debounce latency: stable flips on edge 10, readable after edge 11
        address = 2'd0;
        in_port[0] = 1'b1;
        repeat (DEB + 2) tick();
        checkOutput("dataBeforeWindow", readdata, 32'h0);
        tick();
        checkOutput("dataAfterWindow", readdata, 32'h1);

        // Short glitch is rejected
        busWrite(2'd2, 32'hF);
        address = 2'd0;
        in_port[0] = 1'b0;
        repeat (5) tick();
        in_port[0] = 1'b1;
        repeat (DEB + 4) tick();
        checkOutput("glitchData", readdata, 32'h1);
        busRead(2'd2, value);
        checkOutput("glitchCapture", value, 32'h0);

        // Edge capture and interrupt
        busWrite(2'd3, 32'hF);
        busWrite(2'd1, 32'h2);
        address = 2'd2;
        in_port[1] = 1'b1;
        repeat (DEB + 3) tick();
        checkOutput("irqBeforeCapture", {31'b0, irq}, 32'h0);
        tick();
        checkOutput("captureBit1", readdata, 32'h2);
        checkOutput("irqAsserted", {31'b0, irq}, 32'h1);
        busWrite(2'd2, 32'h2);
        checkOutput("irqOnClearEdge", {31'b0, irq}, 32'h1);
        tick();
        checkOutput("captureCleared", readdata, 32'h0);
        checkOutput("irqCleared", {31'b0, irq}, 32'h0);

        // Falling-edge polarity with interrupts masked
        busWrite(2'd1, 32'h0);
        busWrite(2'd3, 32'h0);
        address = 2'd2;
        in_port[2] = 1'b1;
        repeat (DEB + 5) tick();
        checkOutput("polRiseIgnored", readdata, 32'h0);
        in_port[2] = 1'b0;
        repeat (DEB + 5) tick();
        checkOutput("polFallCaptured", readdata, 32'h4);
        checkOutput("polIrqMasked", {31'b0, irq}, 32'h0);

        // Two bits stepping together appear in the same cycle
        busWrite(2'd3, 32'hF);
        in_port = '0;
        repeat (DEB + 5) tick();
        busWrite(2'd2, 32'hF);
        address = 2'd2;
        in_port = 4'b1001;
        repeat (DEB + 3) tick();
        checkOutput("multiBeforeCapture", readdata, 32'h0);
        tick();
        checkOutput("multiCapture", readdata, 32'h9);

        // Set and W1C on bit 3 in the same cycle: set wins
        busWrite(2'd2, 32'hF);
        in_port[3] = 1'b0;
        repeat (DEB + 5) tick();
        in_port[3] = 1'b1;
        for (int n = 0; n < 4 * DEB && !mEvq[3]; n++) tick();
        if (!mEvq[3]) checkOutput("collisionTimeout", 32'h0, 32'h1);
        busWrite(2'd2, 32'h8);
        busRead(2'd2, value);
        checkOutput("collisionCapture", value, 32'h8);

        // Randomised traffic
        applyStimulus(200);

        // Reset in the middle of a count with irq active
        busWrite(2'd3, 32'hF);
        busWrite(2'd1, 32'hF);
        in_port = '0;
        repeat (2 * DEB + 4) tick();
        busWrite(2'd2, 32'hF);
        in_port = 4'hF;
        repeat (DEB + 4) tick();
        in_port = '0;
        repeat (DEB + 4) tick();
        in_port = 4'hF;
        address = 2'd2;
        repeat (6) tick();
        checkOutput("preResetIrq", {31'b0, irq}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("asyncResetReaddata", readdata, 32'h0);
        checkOutput("asyncResetIrq", {31'b0, irq}, 32'h0);
        resetModel();
        address = 2'd0;
        tick();
        #2 reset_n = 1'b1;
        repeat (DEB + 2) tick();
        checkOutput("requalifyEarly", readdata, 32'h0);
        tick();
        checkOutput("requalifyDone", readdata, 32'hF);
        busRead(2'd3, value);
        checkOutput("postResetPolarity", value, 32'h0000_000F);
        busRead(2'd1, value);
        checkOutput("postResetMask", value, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
